poly_sqrt_pipe: RTL and testbench
=================================

// Module: poly_sqrt_pipe
// PURPOSE
//  Parametrised, pipelined piecewise-linear square-root unit for the noise-generator datapath.
//  Computes y = ((x*C1[seg]) >> PROD_SHIFT) + (C0[seg] >> C0_SHIFT), where seg = x[DIN_W-1 -: SEG_BITS].
//  Adds a run-time coefficient load port, valid/ready flow control, selectable rounding and output saturation.
// PARAMETERS
//  DIN_W      31  input width, unsigned
//  SEG_BITS   6   segment-index bits; table depth = 2**SEG_BITS
//  C1_W       12  slope coefficient width, unsigned
//  C0_W       20  offset coefficient width, unsigned
//  DOUT_W     17  output width (4 integer + 13 fraction bits at defaults)
//  PROD_SHIFT 23  right shift applied to the product
//  C0_SHIFT   4   right shift applied to C0
//  ROUND      0   0 = truncate; 1 = round-half-up on the product shift
// PORTS
//  clock      in   1            rising-edge clock
//  reset      in   1            asynchronous, active-low reset
//  in_valid   in   1            input sample valid
//  in_ready   out  1            unit can accept a sample
//  Datain     in   DIN_W        operand x
//  out_valid  out  1            DataOut is valid
//  out_ready  in   1            downstream accepts DataOut
//  DataOut    out  DOUT_W       sqrt result
//  sat        out  1            DataOut was saturated; qualified by out_valid
//  cfg_we     in   1            coefficient write strobe
//  cfg_addr   in   SEG_BITS     table entry to write
//  cfg_c1     in   C1_W         slope value to write
//  cfg_c0     in   C0_W         offset value to write
// BEHAVIOUR
//  Reset (reset=0, async): out_valid=0, DataOut=0, sat=0, all stage valids=0, all C1/C0 entries=0.
//    Tables must be reloaded after every reset.
//  Stall: en = !out_valid | out_ready. in_ready = en, driven combinationally.
//    When en=0, every pipeline register holds its value.
//  Transfers: an input transfers on in_valid & in_ready; an output transfers on out_valid & out_ready.
//  Pipeline (all registers advance only when en=1). Valid bits travel with the data; bubbles are not collapsed.
//    S1: register x, C1[seg] and C0[seg]; v1 <= in_valid.
//    S2: prod = x*C1 at DIN_W+C1_W bits; register prod and C0; v2 <= v1.
//    S3: p = (prod + (ROUND ? 1<<(PROD_SHIFT-1) : 0)) >> PROD_SHIFT.
//        sum = p + (C0 >> C0_SHIFT), evaluated at full width so there is no carry loss.
//        If sum >= 2**DOUT_W: DataOut = all ones, sat = 1. Otherwise DataOut = sum[DOUT_W-1:0], sat = 0.
//        out_valid <= v2.
//  Latency: exactly 3 clocks from input transfer to out_valid when no stall occurs.
//    Throughput is 1 sample per clock. Output order equals input order.
//  Coefficient write: on cfg_we=1, C1[cfg_addr] and C0[cfg_addr] are written at the clock edge.
//    Writes are accepted independently of en.
//    Same-cycle lookup of the same address returns the OLD entry (read-before-write).
//    Samples already past S1 keep the coefficients they captured.
//  Segments: seg 0 covers x in [0, 2**(DIN_W-SEG_BITS)). Datain=0 yields C0[0]>>C0_SHIFT.
//    There is no special case for zero.
//  While out_ready=0 and out_valid=1, DataOut and sat stay stable.
//  in_valid while in_ready=0 is ignored; the sample is not captured.
//  Reset mid-operation drops all in-flight samples; no out_valid follows.
// TESTING
//  1 Load C1[0]=12'h911, C0[0]=20'h0C061; Datain=0, out_ready=1
//    -> DataOut=17'h00C06, sat=0, 3 clocks later.
//  2 Load C1[32]=12'h0FE, C0[32]=20'h80FDC; Datain=31'h4000_0000
//    -> DataOut=17'h0FFFD, sat=0. Repeat with ROUND=1: same value (no rounding bit set).
//  3 Load C1[63]=12'hFFF, C0[63]=20'hFFFFF; Datain=31'h7FFF_FFFF
//    -> DataOut=17'h1FFFF, sat=1.
//  4 Stream 8 back-to-back samples with out_ready toggling 1,0,0,1,...
//    -> no loss or duplication, in order; in_ready=0 exactly when out_valid & !out_ready.
//  5 cfg_we to addr 5 in the same cycle an in_valid sample hits seg 5
//    -> that sample uses the old coefficients; the next sample uses the new ones.
//  6 Assert reset with 3 samples in flight -> all outputs 0 at once; no out_valid after release.

Source files
------------

// File: rtl/poly_sqrt_pipe.sv
// Three-stage piecewise-linear square-root unit with run-time loadable segment tables,
// a single global stall (valid/ready) and output saturation.
module poly_sqrt_pipe #(
   parameter int DIN_W      = 31,
   parameter int SEG_BITS   = 6,
   parameter int C1_W       = 12,
   parameter int C0_W       = 20,
   parameter int DOUT_W     = 17,
   parameter int PROD_SHIFT = 23,
   parameter int C0_SHIFT   = 4,
   parameter int ROUND      = 0
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DIN_W-1:0]    Datain,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DOUT_W-1:0]   DataOut,
   output logic                sat,
   input  logic                cfg_we,
   input  logic [SEG_BITS-1:0] cfg_addr,
   input  logic [C1_W-1:0]     cfg_c1,
   input  logic [C0_W-1:0]     cfg_c0
);

   localparam int DEPTH = 1 << SEG_BITS;
   localparam int PW    = DIN_W + C1_W;
   localparam int SUM_W = ((PW > C0_W) ? PW : C0_W) + 2;
   localparam logic [SUM_W-1:0] RND_ADD =
      (ROUND != 0) ? (SUM_W'(1) << (PROD_SHIFT - 1)) : '0;

   logic [C1_W-1:0]     c1_tab_q [DEPTH];
   logic [C1_W-1:0]     c1_tab_d [DEPTH];
   logic [C0_W-1:0]     c0_tab_q [DEPTH];
   logic [C0_W-1:0]     c0_tab_d [DEPTH];

   logic [DIN_W-1:0]    x1_q, x1_d;
   logic [C1_W-1:0]     c1_1_q, c1_1_d;
   logic [C0_W-1:0]     c0_1_q, c0_1_d;
   logic                v1_q, v1_d;
   logic [PW-1:0]       prod_q, prod_d;
   logic [C0_W-1:0]     c0_2_q, c0_2_d;
   logic                v2_q, v2_d;
   logic [DOUT_W-1:0]   dout_q, dout_d;
   logic                sat_q, sat_d;
   logic                out_valid_q, out_valid_d;

   logic                en;
   logic [SEG_BITS-1:0] seg;
   logic [SUM_W-1:0]    p_full;
   logic [SUM_W-1:0]    sum;
   logic                sum_sat;
   logic [DOUT_W-1:0]   sum_dout;

   assign seg       = Datain[DIN_W-1 -: SEG_BITS];
   assign en        = !out_valid_q || out_ready;
   assign in_ready  = en;
   assign out_valid = out_valid_q;
   assign DataOut   = dout_q;
   assign sat       = sat_q;

   // Lookups read the registered tables, so a same-cycle write is seen only by later samples.
   always_comb begin
      c1_tab_d = c1_tab_q;
      c0_tab_d = c0_tab_q;
      if (cfg_we) begin
         c1_tab_d[cfg_addr] = cfg_c1;
         c0_tab_d[cfg_addr] = cfg_c0;
      end
   end

   always_comb begin
      p_full   = (SUM_W'(prod_q) + RND_ADD) >> PROD_SHIFT;
      sum      = p_full + (SUM_W'(c0_2_q) >> C0_SHIFT);
      sum_sat  = |sum[SUM_W-1:DOUT_W];
      sum_dout = sum_sat ? '1 : sum[DOUT_W-1:0];
   end

   always_comb begin
      x1_d        = x1_q;
      c1_1_d      = c1_1_q;
      c0_1_d      = c0_1_q;
      v1_d        = v1_q;
      prod_d      = prod_q;
      c0_2_d      = c0_2_q;
      v2_d        = v2_q;
      dout_d      = dout_q;
      sat_d       = sat_q;
      out_valid_d = out_valid_q;
      if (en) begin
         x1_d        = Datain;
         c1_1_d      = c1_tab_q[seg];
         c0_1_d      = c0_tab_q[seg];
         v1_d        = in_valid;
         prod_d      = PW'(x1_q) * PW'(c1_1_q);
         c0_2_d      = c0_1_q;
         v2_d        = v1_q;
         dout_d      = sum_dout;
         sat_d       = sum_sat;
         out_valid_d = v2_q;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            c1_tab_q[i] <= '0;
            c0_tab_q[i] <= '0;
         end
      end else begin
         c1_tab_q <= c1_tab_d;
         c0_tab_q <= c0_tab_d;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         x1_q        <= '0;
         c1_1_q      <= '0;
         c0_1_q      <= '0;
         v1_q        <= 1'b0;
         prod_q      <= '0;
         c0_2_q      <= '0;
         v2_q        <= 1'b0;
         dout_q      <= '0;
         sat_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         x1_q        <= x1_d;
         c1_1_q      <= c1_1_d;
         c0_1_q      <= c0_1_d;
         v1_q        <= v1_d;
         prod_q      <= prod_d;
         c0_2_q      <= c0_2_d;
         v2_q        <= v2_d;
         dout_q      <= dout_d;
         sat_q       <= sat_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_poly_sqrt_pipe.sv
// Self-checking bench for poly_sqrt_pipe: truncating and rounding instances driven in parallel,
// checked against an arithmetic reference model with expected-result queues.
module tb_poly_sqrt_pipe;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic [30:0] Datain = '0;
   logic        out_ready = 1'b1;
   logic        cfg_we = 1'b0;
   logic [5:0]  cfg_addr = '0;
   logic [11:0] cfg_c1 = '0;
   logic [19:0] cfg_c0 = '0;

   logic        in_ready, out_valid, sat;
   logic [16:0] DataOut;
   logic        in_ready_r, out_valid_r, sat_r;
   logic [16:0] DataOut_r;

   int checks = 0;
   int failures = 0;
   int out_count = 0;

   int unsigned m_c1 [64];
   int unsigned m_c0 [64];
   logic [17:0] exp0 [$];
   logic [17:0] exp1 [$];

   always #5 clock = ~clock;

   poly_sqrt_pipe u_dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .Datain(Datain), .out_valid(out_valid), .out_ready(out_ready),
      .DataOut(DataOut), .sat(sat), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_c1(cfg_c1), .cfg_c0(cfg_c0)
   );

   poly_sqrt_pipe #(.ROUND(1)) u_dut_r (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_r),
      .Datain(Datain), .out_valid(out_valid_r), .out_ready(out_ready),
      .DataOut(DataOut_r), .sat(sat_r), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_c1(cfg_c1), .cfg_c0(cfg_c0)
   );

   // Returns {sat, DataOut} for one sample.
   function automatic logic [17:0] model_y(input longint unsigned x, input longint unsigned c1,
                                           input longint unsigned c0, input bit rnd);
      longint unsigned prod, p, s;
      prod = x * c1;
      p    = (prod + (rnd ? (64'd1 << 22) : 64'd0)) >> 23;
      s    = p + (c0 >> 4);
      if (s >= 64'd131072) return {1'b1, 17'h1FFFF};
      return {1'b0, s[16:0]};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic cfg_write(input logic [5:0] a, input logic [11:0] c1, input logic [19:0] c0);
      cfg_we = 1'b1; cfg_addr = a; cfg_c1 = c1; cfg_c0 = c0;
      step();
      cfg_we = 1'b0;
   endtask

   task automatic get_one(input logic [30:0] x, output logic [17:0] r0, output logic [17:0] r1,
                          output int lat);
      out_ready = 1'b1;
      in_valid = 1'b1; Datain = x;
      step();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         step();
         lat++;
      end
      chk("get_one_timeout", out_valid, 1);
      r0 = {sat, DataOut};
      r1 = {sat_r, DataOut_r};
   endtask

   // Cycle monitor: everything here is evaluated mid-cycle, i.e. for the upcoming edge.
   logic        prev_stall = 1'b0;
   logic [17:0] prev_out0, prev_out1;
   always @(negedge clock) begin
      if (!reset) begin
         exp0.delete(); exp1.delete();
         for (int i = 0; i < 64; i++) begin m_c1[i] = 0; m_c0[i] = 0; end
         prev_stall = 1'b0;
      end else begin
         chk("in_ready", in_ready, !(out_valid && !out_ready));
         chk("in_ready_r", in_ready_r, in_ready);
         chk("out_valid_r", out_valid_r, out_valid);
         if (prev_stall) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_hold", {sat, DataOut}, prev_out0);
            chk("stall_hold_r", {sat_r, DataOut_r}, prev_out1);
         end
         if (out_valid && out_ready) begin
            out_count++;
            if (exp0.size() == 0) begin
               chk("spurious_out_valid", 1, 0);
            end else begin
               chk("dout_trunc", {sat, DataOut}, exp0.pop_front());
               chk("dout_round", {sat_r, DataOut_r}, exp1.pop_front());
            end
         end
         if (in_valid && in_ready) begin
            exp0.push_back(model_y(Datain, m_c1[Datain[30:25]], m_c0[Datain[30:25]], 1'b0));
            exp1.push_back(model_y(Datain, m_c1[Datain[30:25]], m_c0[Datain[30:25]], 1'b1));
         end
         if (cfg_we) begin
            m_c1[cfg_addr] = cfg_c1;
            m_c0[cfg_addr] = cfg_c0;
         end
         prev_stall = out_valid && !out_ready;
         prev_out0  = {sat, DataOut};
         prev_out1  = {sat_r, DataOut_r};
      end
   end

   logic [17:0] r0, r1;
   logic [17:0] got [2];
   int lat, n, start_cnt, sent;

   initial begin
      #12;
      chk("reset_out_valid", out_valid, 0);
      chk("reset_dataout", DataOut, 0);
      chk("reset_sat", sat, 0);
      @(posedge clock); #1;
      reset = 1'b1;
      step();
      chk("idle_in_ready", in_ready, 1);

      // Literal pins of the reference model.
      chk("model_t1", model_y(0, 'h911, 'h0C061, 0), {1'b0, 17'h00C06});
      chk("model_t2", model_y('h4000_0000, 'h0FE, 'h80FDC, 0), {1'b0, 17'h0FFFD});
      chk("model_t2r", model_y('h4000_0000, 'h0FE, 'h80FDC, 1), {1'b0, 17'h0FFFD});
      chk("model_t3", model_y('h7FFF_FFFF, 'hFFF, 'hFFFFF, 0), {1'b1, 17'h1FFFF});
      chk("model_rnd", model_y('h0000_8000, 'h100, 0, 1), {1'b0, 17'h00001});

      cfg_write(6'd0, 12'h911, 20'h0C061);
      get_one(31'h0, r0, r1, lat);
      chk("t1_dout", r0, {1'b0, 17'h00C06});
      chk("t1_latency", lat, 3);

      cfg_write(6'd32, 12'h0FE, 20'h80FDC);
      get_one(31'h4000_0000, r0, r1, lat);
      chk("t2_dout", r0, {1'b0, 17'h0FFFD});
      chk("t2_dout_round", r1, {1'b0, 17'h0FFFD});
      chk("t2_latency", lat, 3);

      cfg_write(6'd63, 12'hFFF, 20'hFFFFF);
      get_one(31'h7FFF_FFFF, r0, r1, lat);
      chk("t3_dout", r0, {1'b1, 17'h1FFFF});
      chk("t3_dout_round", r1, {1'b1, 17'h1FFFF});
      step();

      // Same-cycle table write against a lookup of the same segment.
      cfg_write(6'd5, 12'h100, 20'h00010);
      cfg_we = 1'b1; cfg_addr = 6'd5; cfg_c1 = 12'h200; cfg_c0 = 20'h00020;
      in_valid = 1'b1; Datain = 31'h0A00_0000;
      step();
      cfg_we = 1'b0;
      step();
      in_valid = 1'b0;
      n = 0;
      for (int i = 0; i < 20 && n < 2; i++) begin
         if (out_valid) begin got[n] = {sat, DataOut}; n++; end
         step();
      end
      chk("t5_count", n, 2);
      chk("t5_old_coef", got[0], {1'b0, 17'h01401});
      chk("t5_new_coef", got[1], {1'b0, 17'h02802});

      // Eight back-to-back samples, out_ready pattern 1,0,0.
      start_cnt = out_count;
      sent = 0;
      for (int c = 0; c < 60 && sent < 8; c++) begin
         out_ready = (c % 3 == 0);
         in_valid = 1'b1;
         Datain = $urandom() & 31'h7FFF_FFFF;
         #1;
         if (in_ready) sent++;
         step();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (8) step();
      chk("t4_sent", sent, 8);
      chk("t4_out_count", out_count - start_cnt, 8);

      // Randomised table contents, traffic, back-pressure and table writes.
      for (int a = 0; a < 64; a++) cfg_write(a[5:0], 12'($urandom()), 20'($urandom()));
      for (int c = 0; c < 1500; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         Datain    = ($urandom_range(0, 7) == 0) ? (31'h7F00_0000 | 31'($urandom_range(0, 'hFFFFFF)))
                                                 : 31'($urandom());
         out_ready = (c < 60) ? (c % 3 == 0) : ($urandom_range(0, 2) != 0);
         cfg_we    = ($urandom_range(0, 7) == 0);
         cfg_addr  = 6'($urandom());
         cfg_c1    = 12'($urandom());
         cfg_c0    = 20'($urandom());
         step();
      end
      in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
      repeat (8) step();
      chk("drain_empty", exp0.size(), 0);

      // Reset with three samples in flight.
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; Datain = 31'($urandom());
         step();
      end
      in_valid = 1'b0;
      chk("pre_reset_valid", out_valid, 1);
      reset = 1'b0;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_dataout", DataOut, 0);
      chk("rst_sat", sat, 0);
      step();
      reset = 1'b1;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (out_valid) n++;
      end
      chk("post_reset_quiet", n, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
